// File: rtl/mc_bus_pkg.sv
// Shared types and constants for the MCU memory-controller bus master.
// Command words are packed as {write, add, data}, with write in the MSB.
package mc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } mc_state_e;

  localparam int DEF_SETUP_CYCLES  = 3;
  localparam int DEF_STROBE_CYCLES = 6;
  localparam int DEF_HOLD_CYCLES   = 3;

  function automatic int cmd_width(input int add_w, input int data_w);
    return 1 + add_w + data_w;
  endfunction

endpackage

// File: rtl/mc_cmd_fifo.sv
// Synchronous command FIFO. Pushes while full, pops while empty and any
// push or pop in a flush cycle are all ignored.
module mc_cmd_fifo #(
  parameter int WIDTH = 23,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_s, pop_s;

  assign full_o    = (count_q == CNT_FULL);
  assign empty_o   = (count_q == CNT_ZERO);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign push_s    = push_i && !full_o && !flush_i;
  assign pop_s     = pop_i && !empty_o && !flush_i;

  // Storage array; contents are qualified by count, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= CNT_ZERO;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= CNT_ZERO;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_s)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mc_bus_master.sv
// Queued command engine driving the MCU parallel memory-controller bus.
// Define MC_BUS_MASTER_WAIT_EN to add the mc_wait input that stretches STROBE.
module mc_bus_master
  import mc_bus_pkg::*;
#(
  parameter int MC_DATA_WIDTH = 16,
  parameter int MC_ADD_WIDTH  = 6,
  parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
  parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int CNT_WIDTH     = 4,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [MC_ADD_WIDTH-1:0]  cmd_add,
  input  logic [MC_DATA_WIDTH-1:0] cmd_data,
  output logic                     rsp_valid,
  output logic [MC_DATA_WIDTH-1:0] rsp_data,
  output logic                     busy,
  output logic [MC_ADD_WIDTH-1:0]  mc_add,
  output logic [MC_DATA_WIDTH-1:0] mc_data_out,
  output logic                     mc_data_oe,
  input  logic [MC_DATA_WIDTH-1:0] mc_data_in,
`ifdef MC_BUS_MASTER_WAIT_EN
  input  logic                     mc_wait,
`endif
  output logic                     mc_ce,
  output logic                     mc_we,
  output logic                     mc_oe
);

  localparam int CW  = cmd_width(MC_ADD_WIDTH, MC_DATA_WIDTH);
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO    = CNT_WIDTH'(0);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] SETUP_LOAD  = CNT_WIDTH'(SETUP_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] STROBE_LOAD = CNT_WIDTH'(STROBE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_LOAD   = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [FCW-1:0]       FCNT_ZERO   = FCW'(0);

  mc_state_e                state_q;
  logic [CNT_WIDTH-1:0]     cnt_q;
  logic                     wr_q;
  logic [MC_ADD_WIDTH-1:0]  mc_add_q;
  logic [MC_DATA_WIDTH-1:0] mc_data_out_q, rsp_data_q;
  logic                     mc_data_oe_q, mc_ce_q, mc_we_q, mc_oe_q, rsp_valid_q;

  logic [CW-1:0]            head_s;
  logic                     fifo_full_s, fifo_empty_s, fifo_avail_s;
  logic [FCW-1:0]           fifo_count_s;
  logic                     phase_end_s, pop_s, wait_s;

  mc_cmd_fifo #(
    .WIDTH (CW),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk_i     (clock),
    .rst_ni    (reset),
    .push_i    (cmd_valid),
    .pop_i     (pop_s),
    .flush_i   (flush),
    .wr_data_i ({cmd_write, cmd_add, cmd_data}),
    .rd_data_o (head_s),
    .full_o    (fifo_full_s),
    .empty_o   (fifo_empty_s),
    .count_o   (fifo_count_s)
  );

`ifdef MC_BUS_MASTER_WAIT_EN
  logic wait_meta_q, wait_sync_q;

  // Two-flop synchroniser for the asynchronous wait request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_meta_q <= 1'b0;
      wait_sync_q <= 1'b0;
    end else begin
      wait_meta_q <= mc_wait;
      wait_sync_q <= wait_meta_q;
    end
  end

  assign wait_s = wait_sync_q;
`else
  assign wait_s = 1'b0;
`endif

  // A flushed head is never started, so the flush really empties the queue.
  always_comb begin
    fifo_avail_s = !fifo_empty_s && !flush;
    phase_end_s  = (cnt_q == CNT_ZERO);
    if (fifo_avail_s && ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && phase_end_s))) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Bus sequencer; starting a new command takes priority over the phase logic.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= CNT_ZERO;
      wr_q          <= 1'b0;
      mc_add_q      <= '0;
      mc_data_out_q <= '0;
      mc_data_oe_q  <= 1'b0;
      mc_ce_q       <= 1'b1;
      mc_we_q       <= 1'b1;
      mc_oe_q       <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (pop_s) begin
        state_q       <= ST_SETUP;
        cnt_q         <= SETUP_LOAD;
        wr_q          <= head_s[CW-1];
        mc_add_q      <= head_s[CW-2 -: MC_ADD_WIDTH];
        mc_data_out_q <= head_s[MC_DATA_WIDTH-1:0];
        mc_data_oe_q  <= head_s[CW-1];
        mc_ce_q       <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: state_q <= ST_IDLE;
          ST_SETUP: begin
            if (phase_end_s) begin
              state_q <= ST_STROBE;
              cnt_q   <= STROBE_LOAD;
              mc_we_q <= !wr_q;
              mc_oe_q <= wr_q;
            end else begin
              cnt_q <= cnt_q - CNT_ONE;
            end
          end
          ST_STROBE: begin
            if (phase_end_s && !wait_s) begin
              state_q <= ST_HOLD;
              cnt_q   <= HOLD_LOAD;
              mc_we_q <= 1'b1;
              mc_oe_q <= 1'b1;
              if (!wr_q) begin
                rsp_data_q  <= mc_data_in;
                rsp_valid_q <= 1'b1;
              end
            end else if (!phase_end_s) begin
              cnt_q <= cnt_q - CNT_ONE;
            end
          end
          ST_HOLD: begin
            if (phase_end_s) begin
              state_q      <= ST_IDLE;
              mc_ce_q      <= 1'b1;
              mc_data_oe_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q - CNT_ONE;
            end
          end
          default: begin
            state_q      <= ST_IDLE;
            mc_ce_q      <= 1'b1;
            mc_we_q      <= 1'b1;
            mc_oe_q      <= 1'b1;
            mc_data_oe_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cmd_ready   = !fifo_full_s;
  assign busy        = (state_q != ST_IDLE) || (fifo_count_s != FCNT_ZERO);
  assign mc_add      = mc_add_q;
  assign mc_data_out = mc_data_out_q;
  assign mc_data_oe  = mc_data_oe_q;
  assign mc_ce       = mc_ce_q;
  assign mc_we       = mc_we_q;
  assign mc_oe       = mc_oe_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;

endmodule

// File: tb/tb_mc_bus_master.sv
// Scoreboard bench for mc_bus_master: stimulus queues expected bus cycles and
// read responses, independent monitors pop and compare them at negedge.
module tb_mc_bus_master;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [5:0]  cmd_add = 6'd0;
  logic [15:0] cmd_data = 16'd0;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        busy;
  logic [5:0]  mc_add;
  logic [15:0] mc_data_out;
  logic        mc_data_oe;
  logic [15:0] mc_data_in;
  logic        mc_ce, mc_we, mc_oe;
  logic        mc_wait = 1'b0;

  logic [15:0] rd_mem [64];
  logic        ovr_en = 1'b0;
  logic [15:0] ovr_val = 16'd0;
  assign mc_data_in = ovr_en ? ovr_val : rd_mem[mc_add];

  typedef struct {
    logic        w;
    logic [5:0]  a;
    logic [15:0] d;
    int          slen;
  } txn_t;

  txn_t        bus_q[$];
  logic [15:0] rsp_q[$];
  int checks = 0;
  int errors = 0;
  int sent_cnt = 0;
  int first_stall = -1;

  mc_bus_master dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_add     (cmd_add),
    .cmd_data    (cmd_data),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .busy        (busy),
    .mc_add      (mc_add),
    .mc_data_out (mc_data_out),
    .mc_data_oe  (mc_data_oe),
    .mc_data_in  (mc_data_in),
`ifdef MC_BUS_MASTER_WAIT_EN
    .mc_wait     (mc_wait),
`endif
    .mc_ce       (mc_ce),
    .mc_we       (mc_we),
    .mc_oe       (mc_oe)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic send(input logic w, input logic [5:0] a, input logic [15:0] d,
                      input bit expect_bus, input int slen);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_add   = a;
    cmd_data  = d;
    if (!cmd_ready && first_stall < 0) first_stall = sent_cnt;
    while (!cmd_ready && n < 500) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (n >= 500) check("send_timeout", 32'(n), 32'd0);
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    sent_cnt++;
    if (expect_bus) begin
      bus_q.push_back('{w: w, a: a, d: d, slen: slen});
      if (!w) rsp_q.push_back(d);
    end
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    @(negedge clock);
    while (busy && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check(nm, 32'({busy, mc_ce}), 32'b01);
    @(posedge clock);
    #1;
  endtask

  // Bus monitor: strobe contents, phase spacing and chip-enable run lengths.
  int   ce_run = 0, exp_run = 0, gap = 0, nstrobe = 0, slen_cnt = 0, cur_slen = 0;
  logic in_strobe = 1'b0, prev_ce = 1'b1, strobe_now;
  txn_t cur;
  initial forever begin
    @(negedge clock);
    if (!reset) begin
      in_strobe = 1'b0;
      ce_run = 0; exp_run = 0; gap = 0; nstrobe = 0;
      prev_ce = 1'b1;
    end else begin
      strobe_now = !mc_we || !mc_oe;
      if (!mc_ce) ce_run++;
      if (strobe_now && !in_strobe) begin
        check("strobe_excl", 32'(mc_we | mc_oe), 32'd1);
        if (bus_q.size() == 0) begin
          check("unexpected_strobe_add", 32'(mc_add), 32'hFFFF_FFFF);
        end else begin
          cur = bus_q.pop_front();
          check("strobe_kind_we", 32'(mc_we), 32'(!cur.w));
          check("bus_add", 32'(mc_add), 32'(cur.a));
          if (cur.w) check("bus_wdata", 32'(mc_data_out), 32'(cur.d));
          check("bus_data_oe", 32'(mc_data_oe), 32'(cur.w));
          check("setup_gap", 32'(gap), (nstrobe == 0) ? 32'd3 : 32'd6);
          cur_slen = cur.slen;
          exp_run += 6 + cur.slen;
        end
        gap = 0;
        slen_cnt = 1;
        nstrobe++;
        in_strobe = 1'b1;
      end else if (strobe_now) begin
        slen_cnt++;
      end else begin
        if (in_strobe) begin
          check("strobe_len", 32'(slen_cnt), 32'(cur_slen));
          in_strobe = 1'b0;
        end
        if (!mc_ce) gap++;
      end
      if (mc_ce && !prev_ce) begin
        check("txn_len", 32'(ce_run), 32'(exp_run));
        ce_run = 0; exp_run = 0; gap = 0; nstrobe = 0;
      end
      prev_ce = mc_ce;
    end
  end

  // Response monitor: every rsp_valid cycle must match a queued read.
  initial forever begin
    @(negedge clock);
    if (reset && rsp_valid) begin
      if (rsp_q.size() == 0) check("unexpected_rsp", 32'(rsp_data), 32'hFFFF_FFFF);
      else check("rsp_data", 32'(rsp_data), 32'(rsp_q.pop_front()));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 64; k++) rd_mem[k] = 16'h5000 | 16'(k);
    rd_mem[5] = 16'hA55A;

    // Reset state
    #12;
    check("rst_strobes", 32'({mc_we, mc_oe, mc_ce}), 32'b111);
    check("rst_add_data", 32'({mc_add, mc_data_out}), 32'd0);
    check("rst_oe_rsp", 32'({mc_data_oe, rsp_valid, busy}), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Single write with one-cycle start latency
    send(1'b1, 6'h01, 16'h00FF, 1'b1, 6);
    @(negedge clock);
    check("lat_not_yet", 32'({mc_ce, busy}), 32'b11);
    @(negedge clock);
    check("lat_add", 32'(mc_add), 32'h01);
    check("lat_ce_oe", 32'({mc_ce, mc_data_oe, mc_we}), 32'b011);
    wait_idle("idle_after_write");

    // Single read
    send(1'b0, 6'h05, 16'hA55A, 1'b1, 6);
    wait_idle("idle_after_read");

    // Ten back-to-back commands through an eight-deep queue
    sent_cnt = 0;
    first_stall = -1;
    for (int i = 0; i < 10; i++) begin
      if (i % 3 == 2) send(1'b0, 6'(6'h10 + i), rd_mem[6'h10 + i], 1'b1, 6);
      else            send(1'b1, 6'(6'h10 + i), 16'(16'h1000 + i), 1'b1, 6);
    end
    check("first_stall_at", 32'(first_stall), 32'd9);
    wait_idle("idle_after_burst");

    // Flush during the second of five writes, with a same-cycle push
    for (int i = 0; i < 5; i++) send(1'b1, 6'(6'h20 + i), 16'(16'hF000 + i), (i < 2), 6);
    begin
      int n = 0;
      @(negedge clock);
      while (!(mc_add == 6'h21 && !mc_we) && n < 300) begin
        @(negedge clock);
        n++;
      end
      check("flush_reach_2nd", 32'(n < 300), 32'd1);
    end
    flush = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_add = 6'h3F; cmd_data = 16'hDEAD;
    @(posedge clock);
    #1;
    flush = 1'b0;
    cmd_valid = 1'b0;
    wait_idle("idle_after_flush");
    repeat (20) @(posedge clock);
    #1;

    // Asynchronous reset during a write strobe with a second command queued
    send(1'b1, 6'h2A, 16'h1234, 1'b1, 6);
    send(1'b1, 6'h2B, 16'h4321, 1'b0, 6);
    begin
      int n = 0;
      @(negedge clock);
      while (mc_we && n < 300) begin
        @(negedge clock);
        n++;
      end
      check("rst_reach_strobe", 32'(n < 300), 32'd1);
    end
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_we_ce", 32'({mc_we, mc_ce, mc_oe}), 32'b111);
    bus_q.delete();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    repeat (20) @(posedge clock);
    #1;
    check("post_rst_idle", 32'({busy, mc_ce, cmd_ready}), 32'b011);

`ifdef MC_BUS_MASTER_WAIT_EN
    // Wait raised in strobe cycle 4 for four cycles stretches STROBE to 10
    ovr_en = 1'b1;
    ovr_val = 16'h1111;
    send(1'b0, 6'h07, 16'hBEEF, 1'b1, 10);
    begin
      int n = 0;
      @(negedge clock);
      while (mc_oe && n < 300) begin
        @(negedge clock);
        n++;
      end
      check("wait_reach_strobe", 32'(n < 300), 32'd1);
    end
    repeat (3) @(negedge clock);
    mc_wait = 1'b1;
    repeat (4) @(negedge clock);
    mc_wait = 1'b0;
    ovr_val = 16'hBEEF;
    wait_idle("idle_after_wait");
    ovr_en = 1'b0;
`endif

    repeat (5) @(posedge clock);
    #1;
    check("bus_q_drained", 32'(bus_q.size()), 32'd0);
    check("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_bus_master.md
Name: mc_bus_master

Overview:
- Synthesizable master for the MCU parallel memory-controller bus (mc_add/mc_data/mc_we/mc_oe/mc_ce). It sits beside top in benches and in hardware self-test builds.
- Replaces fixed-timing write/read sequences with a queued command engine:
  - setup/strobe/hold phase lengths are parametrised;
  - bus widths are parametrised;
  - read data is captured and returned on a response port;
  - back-to-back transactions are supported.

Parameters:
- MC_DATA_WIDTH, 16, bus data width
- MC_ADD_WIDTH, 6, bus address width
- SETUP_CYCLES, 3, cycles address/data are stable before the strobe (>=1)
- STROBE_CYCLES, 6, cycles mc_we/mc_oe are held low (>=1)
- HOLD_CYCLES, 3, cycles after the strobe before the next transaction (>=1)
- CNT_WIDTH, 4, phase counter width; must hold max(SETUP,STROBE,HOLD)
- FIFO_DEPTH, 8, command queue depth, power of 2, >=2

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous; drops all queued commands
- cmd_valid  in  1  command offered
- cmd_ready  out  1  queue can accept (= !full)
- cmd_write  in  1  1 = write, 0 = read
- cmd_add  in  MC_ADD_WIDTH  target address
- cmd_data  in  MC_DATA_WIDTH  write data (ignored for reads)
- rsp_valid  out  1  one-cycle pulse; read data valid
- rsp_data  out  MC_DATA_WIDTH  captured read data
- busy  out  1  transaction in progress or queue non-empty
- mc_add  out  MC_ADD_WIDTH  bus address
- mc_data_out  out  MC_DATA_WIDTH  bus write data
- mc_data_oe  out  1  1 = master drives mc_data
- mc_data_in  in  MC_DATA_WIDTH  bus read data
- mc_ce  out  1  chip enable, active-low
- mc_we  out  1  write strobe, active-low
- mc_oe  out  1  read strobe, active-low

Behaviour:
- Reset values (async, reset=0):
  - mc_we=1, mc_oe=1, mc_ce=1;
  - mc_add=0, mc_data_out=0, mc_data_oe=0;
  - rsp_valid=0, rsp_data=0, busy=0;
  - queue emptied; state IDLE.
- Reset mid-transaction: strobes and mc_ce go high immediately and the transaction is discarded.
- Accept rule: a command is accepted on a clock edge with cmd_valid && cmd_ready. When the queue is full, cmd_ready=0 even if a pop occurs that same cycle.
- FSM states: IDLE, SETUP, STROBE, HOLD. A counter loads phase length minus 1 on each phase entry.
- IDLE:
  - If the queue is non-empty, pop the head.
  - Register mc_add, mc_data_out and the write flag; mc_ce=0; mc_data_oe=write.
  - Go to SETUP.
  - Latency: from accept edge (empty queue) to mc_add valid is 1 cycle.
- SETUP: strobes high for SETUP_CYCLES, then go to STROBE.
- STROBE:
  - Write: mc_we=0; read: mc_oe=0; for STROBE_CYCLES.
  - Read: mc_data_in is sampled on the last STROBE cycle into rsp_data.
  - Go to HOLD.
- HOLD:
  - Strobes high; mc_ce=0; mc_data_oe unchanged; lasts HOLD_CYCLES.
  - rsp_valid pulses on the first HOLD cycle for reads only.
  - On the last HOLD cycle: if the queue is non-empty, pop and go directly to SETUP (no IDLE gap). Otherwise go to IDLE with mc_ce=1 and mc_data_oe=0.
- Transaction length is exactly SETUP+STROBE+HOLD cycles. mc_we and mc_oe are never low together.
- mc_add and mc_data_out are stable from SETUP entry through the end of HOLD.
- flush: empties the queue; the current transaction completes normally. A same-cycle push is dropped.
- busy = (state != IDLE) || queue non-empty.
- A queue pointer wrap at FIFO_DEPTH is transparent.

Optional Feature:
- Macro: MC_BUS_MASTER_WAIT_EN.
- With the macro: adds input mc_wait (1 bit, active-high, synchronised with 2 flops internally).
  - While the synchronised wait is high in the last STROBE cycle, STROBE is extended.
  - Sampling occurs on the first cycle with wait low.
  - Wait is ignored in other states.
- Without the macro: no port, fixed timing.

Decomposition:
- Package mc_bus_pkg:
  - state encoding constants (IDLE/SETUP/STROBE/HOLD);
  - default timing constants (3/6/3);
  - command word layout {write, add, data} and its width function.
- Sub-module mc_cmd_fifo:
  - synchronous FIFO, width 1+MC_ADD_WIDTH+MC_DATA_WIDTH, depth FIFO_DEPTH;
  - ports: push, pop, flush, full, empty, count.

Test Plan:
- Single write add=0x01, data=0x00FF, default timing -> mc_add=0x01 after 1 cycle; mc_we low exactly 6 cycles starting 3 cycles after SETUP entry; mc_data_out=0x00FF; mc_oe stays high; total 12 cycles; busy drops after.
- Single read add=0x05 with mc_data_in=0xA55A -> mc_oe low 6 cycles; rsp_valid one pulse; rsp_data=0xA55A; mc_data_oe=0 throughout.
- Push 10 commands back-to-back with FIFO_DEPTH=8 -> cmd_ready drops after 8 pending (accounting for pops); all 10 execute in order with no IDLE cycle between them; each is 12 cycles.
- flush asserted during the 2nd of 5 queued writes -> the 2nd write completes; writes 3-5 never appear on the bus; FSM reaches IDLE.
- reset deasserted-low during STROBE of a write -> mc_we, mc_ce return to 1 asynchronously; queue empty after reset release; no rsp_valid.
- With MC_BUS_MASTER_WAIT_EN, mc_wait held high 4 cycles during a read -> STROBE extends by 4 cycles (plus sync delay); rsp_data is the value present when wait falls.
